systolic_host_driver: RTL and testbench
=======================================

# systolic_host_driver

Bus-master sequencer that drives the 2x2 systolic peripheral's command port (`wen`/`wdata`/`rdata`). It accepts one operand set (two west, two north values) over a valid/ready handshake, then issues the full command sequence: RESET, four operand writes, START, STATUS polling and four result reads. It returns the four 16-bit results over a second valid/ready handshake. It sits between a host/DMA front end and the peripheral and replaces software polling.

## Interface
- `RD_LAT`, 3: cycles from a read-type command's issue cycle to the edge at which `rdata` is sampled.
- `POLL_MAX`, 64: maximum STATUS polls before the timeout is declared; range 1..255.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low; asserting it immediately clears all state.
- `job_valid` in 1: operand set offered.
- `job_ready` out 1: block can accept a job.
- `west0`, `west1`, `north0`, `north1` in 16 each: operands, captured on accept.
- `res_valid` out 1: results available.
- `res_ready` in 1: consumer takes the results.
- `res_00`, `res_01`, `res_10`, `res_11` out 16 each: C[i][j] results.
- `res_timeout` out 1: STATUS never reported done; qualified by `res_valid`.
- `busy` out 1: a job is in progress (any state other than IDLE).
- `wen` out 4: peripheral write enable; 4'hF on a command cycle, 4'h0 otherwise.
- `wdata` out 32: command word {opcode[15:0], data[15:0]}.
- `rdata` in 32: peripheral read data; only bits [15:0] are used.

## Operation
- Opcodes: RESET 0x0001, WRITE_WEST_0 0x0002, WRITE_WEST_1 0x0003, WRITE_NORTH_0 0x0004, WRITE_NORTH_1 0x0005, STATUS 0x0006, READ_R00..READ_R11 0x0007..0x000A, START 0x000B.
- States and transitions:
  - IDLE: waits for a job.
  - ISSUE: drives one command.
  - GAP: one idle cycle after a write-type command.
  - WAIT_RD: waits for read data.
  - RESULT: presents results.
  - Transitions: IDLE →(accept) ISSUE → GAP → ISSUE … until the read phase; a read-type ISSUE → WAIT_RD → ISSUE; the last read → RESULT →(`res_ready`) IDLE.
- Step order:
  - RESET (data 0).
  - WRITE_WEST_0/1 and WRITE_NORTH_0/1, each with its captured operand as data.
  - START (data 0).
  - STATUS, repeated while needed.
  - READ_R00, READ_R01, READ_R10, READ_R11.
- Handshakes:
  - `job_ready` = 1 only in IDLE.
  - A job is accepted on the edge where `job_valid` && `job_ready`.
  - `res_valid` is held high in RESULT until `res_ready`. Results are stable while `res_valid` is high.
- STATUS handling:
  - If sampled `rdata[0]` = 1, proceed to the reads.
  - Otherwise increment the 8-bit poll counter and reissue STATUS.
  - When the counter reaches POLL_MAX without done, set `res_timeout`. Still perform the reads and return whatever is read.
- Result capture: each read captures `rdata[15:0]` into the matching `res_xx`. No arithmetic is performed.
- Reset values:
  - Outputs: `wen` 0, `wdata` 0, all `res_xx` 0, `res_valid` 0, `res_timeout` 0, `busy` 0, `job_ready` 1.
  - Internal: state IDLE, poll counter 0.
- Reset mid-job: the job is aborted and `wen` drops to 0 asynchronously. The peripheral is not cleaned up; the next job's leading RESET command restores it.
- `job_valid` in non-IDLE states is ignored. `res_ready` outside RESULT is ignored.

## Timing
- Commands are never back-to-back: `wen` is never high on two consecutive cycles.
- Write-type commands occupy 2 cycles (ISSUE + GAP).
- Read-type command:
  - Issued in cycle t.
  - `rdata` sampled at the edge ending cycle t+RD_LAT.
  - Next ISSUE occurs in cycle t+RD_LAT+1.
- First ISSUE (RESET) is in the cycle after the accept edge.
- With k STATUS polls, `res_valid` first goes high 1 + 12 + (RD_LAT+1)·(k+4) cycles after the accept cycle. With RD_LAT = 3 and k = 1, that is 33 cycles.
- Transitions out of RESULT:
  - With `res_ready` high: `job_ready` returns the next cycle, so a new job can be accepted one cycle after the results are taken.
  - `res_valid` && `res_ready` in the first RESULT cycle is legal; the state returns to IDLE on that edge.

## Structure
- Package `systolic_pkg`: opcode localparams, the 16-bit data width, and a command-word pack function. The peripheral side uses the same package.
- Single module, with no sub-module. An optional sub-module `cmd_step_rom` maps step index → opcode/data-select/read-flag.

## Test plan
- Operands west0=3, west1=4, north0=5, north1=6; behavioural peripheral model with done on the 1st poll and results 0x0011/0x0022/0x0033/0x0044 → exact command stream RESET, 0x0002_0003, 0x0003_0004, 0x0004_0005, 0x0005_0006, START, STATUS, R00..R11; `res_valid` at cycle 33; results match; `res_timeout` = 0.
- Model reports done on the 3rd STATUS → three STATUS commands spaced RD_LAT+1 apart; `res_valid` at cycle 41.
- Done never set, POLL_MAX=4 → exactly 4 STATUS commands, then the reads; `res_timeout` = 1 with `res_valid`.
- `res_ready` held low 10 cycles → `res_valid` and results stable; `job_ready` 0 throughout; new job accepted 1 cycle after `res_ready`.
- `reset` low mid-WAIT_RD → `wen` 0 immediately; all outputs at reset values; a subsequent job completes correctly starting with RESET.
- Monitor over all runs: `wen` never high on consecutive cycles; `job_valid` is ignored while `busy`.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic peripheral command port:
// opcodes, data width, command-word packing and host-driver state types.
package systolic_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CMD_W  = 32;

    localparam logic [15:0] OP_RESET         = 16'h0001;
    localparam logic [15:0] OP_WRITE_WEST_0  = 16'h0002;
    localparam logic [15:0] OP_WRITE_WEST_1  = 16'h0003;
    localparam logic [15:0] OP_WRITE_NORTH_0 = 16'h0004;
    localparam logic [15:0] OP_WRITE_NORTH_1 = 16'h0005;
    localparam logic [15:0] OP_STATUS        = 16'h0006;
    localparam logic [15:0] OP_READ_R00      = 16'h0007;
    localparam logic [15:0] OP_READ_R01      = 16'h0008;
    localparam logic [15:0] OP_READ_R10      = 16'h0009;
    localparam logic [15:0] OP_READ_R11      = 16'h000A;
    localparam logic [15:0] OP_START         = 16'h000B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_WAIT_RD,
        ST_RESULT
    } drv_state_t;

    // Command sequence position; everything from STEP_STATUS on is read-type.
    typedef enum logic [3:0] {
        STEP_RESET,
        STEP_W0,
        STEP_W1,
        STEP_N0,
        STEP_N1,
        STEP_START,
        STEP_STATUS,
        STEP_R00,
        STEP_R01,
        STEP_R10,
        STEP_R11
    } step_t;

    function automatic logic [CMD_W-1:0] pack_cmd(input logic [15:0] op,
                                                   input logic [DATA_W-1:0] data);
        return {op, data};
    endfunction

endpackage

// File: rtl/systolic_host_driver_if.sv
// Job/result handshakes and peripheral command bus of the systolic host driver.
interface systolic_host_driver_if;
    import systolic_pkg::*;

    logic              job_valid;
    logic              job_ready;
    logic [DATA_W-1:0] west0;
    logic [DATA_W-1:0] west1;
    logic [DATA_W-1:0] north0;
    logic [DATA_W-1:0] north1;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_00;
    logic [DATA_W-1:0] res_01;
    logic [DATA_W-1:0] res_10;
    logic [DATA_W-1:0] res_11;
    logic              res_timeout;
    logic              busy;

    logic [3:0]        wen;
    logic [CMD_W-1:0]  wdata;
    logic [CMD_W-1:0]  rdata;

    modport master (
        input  job_valid, west0, west1, north0, north1, res_ready, rdata,
        output job_ready, res_valid, res_00, res_01, res_10, res_11,
               res_timeout, busy, wen, wdata
    );

    modport slave (
        output job_valid, west0, west1, north0, north1, res_ready, rdata,
        input  job_ready, res_valid, res_00, res_01, res_10, res_11,
               res_timeout, busy, wen, wdata
    );

endinterface

// File: rtl/systolic_host_driver.sv
// Sequences RESET, operand writes, START, STATUS polling and result reads on the
// systolic peripheral command port for one accepted job, then returns the results.
module systolic_host_driver
    import systolic_pkg::*;
#(
    parameter int unsigned RD_LAT   = 3,
    parameter int unsigned POLL_MAX = 64
) (
    input logic                    clk,
    input logic                    reset,
    systolic_host_driver_if.master bus
);

    drv_state_t state, state_d;
    step_t      step, step_d;
    logic [7:0] wait_cnt, wait_d;
    logic [7:0] poll_cnt, poll_d;
    logic [8:0] poll_inc;

    logic accept;
    logic sample;
    logic timeout_set;
    logic is_read;

    logic [DATA_W-1:0] west0_q, west1_q, north0_q, north1_q;
    logic [DATA_W-1:0] res_00_q, res_01_q, res_10_q, res_11_q;
    logic              timeout_q;

    logic [15:0]       cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              unused_rdata_hi;

    assign unused_rdata_hi = ^bus.rdata[CMD_W-1:DATA_W];
    assign is_read  = (step >= STEP_STATUS);
    assign poll_inc = {1'b0, poll_cnt} + 9'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            step     <= STEP_RESET;
            wait_cnt <= '0;
            poll_cnt <= '0;
        end else begin
            state    <= state_d;
            step     <= step_d;
            wait_cnt <= wait_d;
            poll_cnt <= poll_d;
        end
    end

    always_comb begin
        state_d     = state;
        step_d      = step;
        wait_d      = wait_cnt;
        poll_d      = poll_cnt;
        accept      = 1'b0;
        sample      = 1'b0;
        timeout_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.job_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                    step_d  = STEP_RESET;
                    poll_d  = '0;
                end
            end
            ST_ISSUE: begin
                wait_d  = '0;
                state_d = is_read ? ST_WAIT_RD : ST_GAP;
            end
            ST_GAP: begin
                step_d  = step_t'(step + 4'd1);
                state_d = ST_ISSUE;
            end
            ST_WAIT_RD: begin
                // rdata is valid in the RD_LAT-th cycle after the issue cycle
                if (wait_cnt == 8'(RD_LAT - 1)) begin
                    sample  = 1'b1;
                    state_d = ST_ISSUE;
                    if (step == STEP_STATUS) begin
                        if (bus.rdata[0]) begin
                            step_d = STEP_R00;
                        end else begin
                            poll_d = poll_inc[7:0];
                            if (poll_inc >= 9'(POLL_MAX)) begin
                                timeout_set = 1'b1;
                                step_d      = STEP_R00;
                            end
                        end
                    end else if (step == STEP_R11) begin
                        state_d = ST_RESULT;
                    end else begin
                        step_d = step_t'(step + 4'd1);
                    end
                end else begin
                    wait_d = wait_cnt + 8'd1;
                end
            end
            ST_RESULT: begin
                if (bus.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_op   = OP_RESET;
        cmd_data = '0;
        case (step)
            STEP_RESET:  cmd_op = OP_RESET;
            STEP_W0:     begin cmd_op = OP_WRITE_WEST_0;  cmd_data = west0_q;  end
            STEP_W1:     begin cmd_op = OP_WRITE_WEST_1;  cmd_data = west1_q;  end
            STEP_N0:     begin cmd_op = OP_WRITE_NORTH_0; cmd_data = north0_q; end
            STEP_N1:     begin cmd_op = OP_WRITE_NORTH_1; cmd_data = north1_q; end
            STEP_START:  cmd_op = OP_START;
            STEP_STATUS: cmd_op = OP_STATUS;
            STEP_R00:    cmd_op = OP_READ_R00;
            STEP_R01:    cmd_op = OP_READ_R01;
            STEP_R10:    cmd_op = OP_READ_R10;
            STEP_R11:    cmd_op = OP_READ_R11;
            default:     cmd_op = OP_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            west0_q   <= '0;
            west1_q   <= '0;
            north0_q  <= '0;
            north1_q  <= '0;
            res_00_q  <= '0;
            res_01_q  <= '0;
            res_10_q  <= '0;
            res_11_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                west0_q   <= bus.west0;
                west1_q   <= bus.west1;
                north0_q  <= bus.north0;
                north1_q  <= bus.north1;
                timeout_q <= 1'b0;
            end
            if (timeout_set) timeout_q <= 1'b1;
            if (sample) begin
                case (step)
                    STEP_R00: res_00_q <= bus.rdata[DATA_W-1:0];
                    STEP_R01: res_01_q <= bus.rdata[DATA_W-1:0];
                    STEP_R10: res_10_q <= bus.rdata[DATA_W-1:0];
                    STEP_R11: res_11_q <= bus.rdata[DATA_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Command outputs decode straight from state so an async reset drops wen at once.
    assign bus.wen         = (state == ST_ISSUE) ? 4'hF : 4'h0;
    assign bus.wdata       = (state == ST_ISSUE) ? pack_cmd(cmd_op, cmd_data) : '0;
    assign bus.job_ready   = (state == ST_IDLE);
    assign bus.res_valid   = (state == ST_RESULT);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.res_00      = res_00_q;
    assign bus.res_01      = res_01_q;
    assign bus.res_10      = res_10_q;
    assign bus.res_11      = res_11_q;
    assign bus.res_timeout = timeout_q;

endmodule

// File: tb/tb_systolic_host_driver.sv
// Self-checking bench for systolic_host_driver with a behavioural peripheral model.
module tb_systolic_host_driver;
    import systolic_pkg::*;

    localparam int unsigned RD_LAT   = 3;
    localparam int unsigned POLL_MAX = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    systolic_host_driver_if bus();

    systolic_host_driver #(.RD_LAT(RD_LAT), .POLL_MAX(POLL_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] w0, w1, n0, n1;
        int          done_at;   // STATUS poll that reports done; 0 = never
        logic [63:0] res;       // {r00, r01, r10, r11}
        int          exp_lat;
        logic        exp_to;
    } job_vec_t;

    typedef struct {
        logic [63:0] res;
        logic        to;
    } res_exp_t;

    logic [31:0] cmd_q[$];
    res_exp_t    res_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Peripheral model: read data appears only in the cycle it is sampled.
    int          done_at = 1;
    logic [15:0] model_res[4];
    int          status_seen = 0;
    logic        pipe_v[RD_LAT];
    logic [31:0] pipe_val[RD_LAT];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_val[i] <= '0;
            end
            status_seen <= 0;
        end else begin
            for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_val[i] <= pipe_val[i-1];
            end
            pipe_v[0]   <= 1'b0;
            pipe_val[0] <= '0;
            if (bus.wen == 4'hF) begin
                case (bus.wdata[31:16])
                    OP_RESET: status_seen <= 0;
                    OP_STATUS: begin
                        status_seen <= status_seen + 1;
                        pipe_v[0]   <= 1'b1;
                        pipe_val[0] <= (done_at != 0 && status_seen + 1 >= done_at) ? 32'hA5A5_0001 : 32'hA5A5_0000;
                    end
                    OP_READ_R00: begin pipe_v[0] <= 1'b1; pipe_val[0] <= {16'hA5A5, model_res[0]}; end
                    OP_READ_R01: begin pipe_v[0] <= 1'b1; pipe_val[0] <= {16'hA5A5, model_res[1]}; end
                    OP_READ_R10: begin pipe_v[0] <= 1'b1; pipe_val[0] <= {16'hA5A5, model_res[2]}; end
                    OP_READ_R11: begin pipe_v[0] <= 1'b1; pipe_val[0] <= {16'hA5A5, model_res[3]}; end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rdata = pipe_v[RD_LAT-1] ? pipe_val[RD_LAT-1] : 32'hFFFF_FFFE;

    // Command monitor: scoreboard of the command stream plus spacing rule.
    logic prev_wen = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_wen = 1'b0;
        end else begin
            if (bus.wen != 4'h0) begin
                chk("wen_value", {60'd0, bus.wen}, 64'hF);
                chk("wen_spacing", {63'd0, prev_wen}, 64'd0);
                if (cmd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cmd_unexpected: got %0h expected no command", bus.wdata);
                end else begin
                    logic [31:0] e;
                    e = cmd_q.pop_front();
                    chk("cmd_word", {32'd0, bus.wdata}, {32'd0, e});
                end
            end
            prev_wen = (bus.wen != 4'h0);
        end
    end

    task automatic push_cmds(input job_vec_t v);
        int k;
        k = (v.done_at == 0) ? int'(POLL_MAX) : v.done_at;
        cmd_q.push_back({OP_RESET, 16'h0000});
        cmd_q.push_back({OP_WRITE_WEST_0, v.w0});
        cmd_q.push_back({OP_WRITE_WEST_1, v.w1});
        cmd_q.push_back({OP_WRITE_NORTH_0, v.n0});
        cmd_q.push_back({OP_WRITE_NORTH_1, v.n1});
        cmd_q.push_back({OP_START, 16'h0000});
        for (int i = 0; i < k; i++) cmd_q.push_back({OP_STATUS, 16'h0000});
        cmd_q.push_back({OP_READ_R00, 16'h0000});
        cmd_q.push_back({OP_READ_R01, 16'h0000});
        cmd_q.push_back({OP_READ_R10, 16'h0000});
        cmd_q.push_back({OP_READ_R11, 16'h0000});
        done_at      = v.done_at;
        model_res[0] = v.res[63:48];
        model_res[1] = v.res[47:32];
        model_res[2] = v.res[31:16];
        model_res[3] = v.res[15:0];
    endtask

    function automatic logic [63:0] dut_res();
        return {bus.res_00, bus.res_01, bus.res_10, bus.res_11};
    endfunction

    // Entered and left just after a negedge; the next job can start in the following cycle.
    task automatic run_job(input job_vec_t v, input int hold);
        int       acc;
        logic     found;
        res_exp_t e;
        push_cmds(v);
        res_q.push_back('{res: v.res, to: v.exp_to});
        bus.west0     = v.w0;
        bus.west1     = v.w1;
        bus.north0    = v.n0;
        bus.north1    = v.n1;
        bus.job_valid = 1'b1;
        chk("job_ready_idle", {63'd0, bus.job_ready}, 64'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        // keep offering junk jobs while busy; none may be taken
        bus.west0  = 16'hDEAD;
        bus.west1  = 16'hBEEF;
        bus.north0 = 16'hF00D;
        bus.north1 = 16'h1234;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                found = 1'b1;
                break;
            end
        end
        bus.job_valid = 1'b0;
        chk("res_valid_seen", {63'd0, found}, 64'd1);
        chk("res_latency", 64'(cyc - acc), 64'(v.exp_lat));
        e = res_q.pop_front();
        chk("results", dut_res(), e.res);
        chk("res_timeout", {63'd0, bus.res_timeout}, {63'd0, e.to});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, bus.res_valid}, 64'd1);
            chk("hold_results", dut_res(), e.res);
            chk("hold_job_ready", {63'd0, bus.job_ready}, 64'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("job_ready_after", {63'd0, bus.job_ready}, 64'd1);
        chk("res_valid_after", {63'd0, bus.res_valid}, 64'd0);
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_wen"},       {60'd0, bus.wen}, 64'd0);
        chk({tag, "_wdata"},     {32'd0, bus.wdata}, 64'd0);
        chk({tag, "_results"},   dut_res(), 64'd0);
        chk({tag, "_res_valid"}, {63'd0, bus.res_valid}, 64'd0);
        chk({tag, "_timeout"},   {63'd0, bus.res_timeout}, 64'd0);
        chk({tag, "_busy"},      {63'd0, bus.busy}, 64'd0);
        chk({tag, "_job_ready"}, {63'd0, bus.job_ready}, 64'd1);
    endtask

    job_vec_t vecs[5];

    initial begin
        logic found;
        vecs[0] = '{16'd3,     16'd4,     16'd5,     16'd6,     1, 64'h0011_0022_0033_0044, 33, 1'b0};
        vecs[1] = '{16'h0007,  16'h0008,  16'h0009,  16'h000A,  3, 64'h1234_5678_9ABC_DEF0, 41, 1'b0};
        vecs[2] = '{16'hFFFF,  16'h8000,  16'h0001,  16'h7FFF,  0, 64'hCAFE_BEEF_0000_FFFF, 45, 1'b1};
        vecs[3] = '{16'h0100,  16'h0200,  16'h0300,  16'h0400,  4, 64'h0F0F_F0F0_AAAA_5555, 45, 1'b0};
        vecs[4] = '{16'h0000,  16'h0000,  16'h0000,  16'h0000,  2, 64'h0001_0002_0003_0004, 37, 1'b0};

        bus.job_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.west0     = '0;
        bus.west1     = '0;
        bus.north0    = '0;
        bus.north1    = '0;
        repeat (3) @(negedge clk);
        chk_reset_values("por");
        reset = 1'b1;

        foreach (vecs[i]) run_job(vecs[i], 0);

        // Backpressure on the result handshake.
        run_job(vecs[1], 10);

        // Reset while waiting for STATUS read data.
        push_cmds(vecs[0]);
        bus.west0     = vecs[0].w0;
        bus.west1     = vecs[0].w1;
        bus.north0    = vecs[0].n0;
        bus.north1    = vecs[0].n1;
        bus.job_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.wen == 4'hF && bus.wdata[31:16] == OP_STATUS) begin
                found = 1'b1;
                break;
            end
        end
        chk("status_reached", {63'd0, found}, 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_values("midrst");
        cmd_q.delete();
        @(negedge clk);
        reset = 1'b1;
        run_job(vecs[0], 0);
        run_job(vecs[2], 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000 time units");
        $fatal(1);
    end

endmodule
